i2c_slave_receiver: RTL
=======================

Name: i2c_slave_receiver

Overview:
- Write-only I2C target: oversamples SCL/SDA on i_clk, detects START/STOP, matches a 7-bit device address, ACKs and presents up to MAX_BYTES data bytes per frame.
- Sits on the far end of our 24-bit codec-config I2C sender (address byte + 2 data bytes).
- Used as a codec/register-file model in simulation and as an on-FPGA target for loopback tests.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit target address; matches the codec address.
- MAX_BYTES, 2, data bytes ACKed per frame; later bytes are NACKed.

Ports:
- i_clk  in  1  system clock; must be >= 8x SCL frequency.
- i_rst  in  1  reset.
- i_sclk  in  1  I2C SCL from the master.
- io_sdat  inout  1  I2C SDA; this block only drives 0 or 'z.
- o_data  out  8  last received data byte, MSB first on the wire.
- o_valid  out  1  1-cycle pulse: o_data/o_idx are new.
- o_idx  out  2  data byte index within the frame; 0 = first byte after the address.
- o_frame_done  out  1  1-cycle pulse on STOP ending an addressed frame.
- o_busy  out  1  high from address match until STOP/START.

Interface: reset i_rst, asynchronous, active-low; clock i_clk.

Behaviour:
- Reset values: o_data=0, o_valid=0, o_idx=0, o_frame_done=0, o_busy=0, io_sdat='z, state IDLE.
- Reset asserted mid-frame releases SDA combinationally from the flop; no partial byte is reported.
- Input sampling: SCL and SDA each pass a 2-flop synchronizer plus a previous-value flop.
  - SCL rise = prev 0, cur 1. SCL fall = prev 1, cur 0.
  - START = SDA falls while SCL is 1. STOP = SDA rises while SCL is 1.
  - Detection latency is 3 i_clk after the pin event.
- Data bits are sampled on synced SCL rise and shifted in MSB first. Bit count is 0..7.
- States and transitions:
  - IDLE: on START, go to ADDR with bit count cleared.
  - ADDR: collect 8 bits (7 address bits + R/W).
    - On the SCL fall after bit 8: if addr==DEV_ADDR and R/W==0, drive SDA low, set o_busy, go to ADDR_ACK.
    - Otherwise go to IGNORE and never drive SDA (NACK).
  - ADDR_ACK: hold SDA low until the next SCL fall, then release and go to DATA with o_idx=0.
  - DATA: collect 8 bits. On the SCL fall after bit 8:
    - If byte count < MAX_BYTES: load o_data, pulse o_valid, drive SDA low, go to DATA_ACK.
    - Otherwise: NACK and go to IGNORE. o_valid does not pulse for the excess byte.
  - DATA_ACK: on the next SCL fall, release SDA, increment o_idx (saturates at 3), go to DATA.
  - IGNORE: wait for START or STOP.
- START or STOP has priority over bit sampling in every state:
  - START (repeated start) goes to ADDR, releases SDA, clears the bit count and o_idx, and clears o_busy.
  - STOP goes to IDLE, releases SDA, clears o_busy. If o_busy was 1, o_frame_done pulses in the same cycle.
- A STOP or START in the middle of a byte discards the partial byte; o_valid does not pulse.
- SDA is driven only as 0 or 'z; it is never driven 1.
- The SDA drive change happens 1 i_clk after the synced SCL fall. That is well inside SCL low when i_clk >= 8x SCL.

Decomposition:
- Package i2c_pkg:
  - state enum {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE}
  - constants I2C_RW_WRITE=0, I2C_ACK=0.
  - The sender should be migrated to the same package.
- One sub-module, i2c_line_sync: synchronizes SCL/SDA and outputs scl_rise, scl_fall, start_det, stop_det.

Test Plan:
- Frame addr 0x1A, W, bytes 0x34,0x56, STOP:
  - ACK (SDA=0) on all 3 ACK clocks.
  - o_valid pulses twice: o_data=0x34/o_idx=0, then 0x56/1.
  - o_frame_done pulses once; o_busy ends 0.
- Addr 0x1B, W, byte 0xFF: SDA never driven low, no o_valid, no o_frame_done, o_busy stays 0.
- Addr 0x1A with R/W=1: NACK on the address, state IGNORE, no o_valid; STOP then returns to IDLE.
- Addr 0x1A, W, 3 bytes 0x01,0x02,0x03: first two ACKed and reported; the third is NACKed with no o_valid.
- Addr 0x1A, W, 4 bits of data, then repeated START, addr 0x1A, W, byte 0xAA:
  - The partial byte is dropped.
  - 0xAA is reported with o_idx=0.
- i_rst pulsed low during ADDR_ACK: SDA is 'z within 1 cycle and all outputs are at reset values. After release, a full valid frame is received correctly.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the receiver (and the config sender once it is migrated).
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_ACK      = 1'b0;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into i_clk and derives SCL edges plus START/STOP conditions.
module i2c_line_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  logic scl_s1_q, scl_s2_q, scl_prev_q;
  logic sda_s1_q, sda_s2_q, sda_prev_q;

  // Reset to the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_s1_q   <= scl_i;
      scl_s2_q   <= scl_s1_q;
      scl_prev_q <= scl_s2_q;
      sda_s1_q   <= sda_i;
      sda_s2_q   <= sda_s1_q;
      sda_prev_q <= sda_s2_q;
    end
  end

  assign sda_o       = sda_s2_q;
  assign scl_rise_o  = ~scl_prev_q &  scl_s2_q;
  assign scl_fall_o  =  scl_prev_q & ~scl_s2_q;
  assign start_det_o =  scl_prev_q &  scl_s2_q &  sda_prev_q & ~sda_s2_q;
  assign stop_det_o  =  scl_prev_q &  scl_s2_q & ~sda_prev_q &  sda_s2_q;

endmodule

// File: rtl/i2c_slave_receiver.sv
// Write-only I2C target: matches DEV_ADDR, ACKs up to MAX_BYTES data bytes and reports each one.
module i2c_slave_receiver
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         MAX_BYTES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk,
  inout  wire        io_sdat,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic [1:0] o_idx,
  output logic       o_frame_done,
  output logic       o_busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic sda_oe;

  i2c_state_e state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       full_q, full_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic [1:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;

  i2c_line_sync u_sync (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .scl_i       (i_sclk),
    .sda_i       (io_sdat),
    .sda_o       (sda_s),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      full_q   <= 1'b0;
      shift_q  <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      full_q   <= full_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    full_d   = full_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    idx_d    = idx_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy_q;

    // Bus conditions override bit handling and drop any partial byte.
    if (stop_det) begin
      state_d  = IDLE;
      bitcnt_d = '0;
      full_d   = 1'b0;
      busy_d   = 1'b0;
      done_d   = busy_q;
    end else if (start_det) begin
      state_d  = ADDR;
      bitcnt_d = '0;
      full_d   = 1'b0;
      cnt_d    = '0;
      idx_d    = '0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ADDR, DATA: begin
          if (scl_rise && !full_q) begin
            shift_d = {shift_q[6:0], sda_s};
            if (bitcnt_q == 3'd7) begin
              bitcnt_d = '0;
              full_d   = 1'b1;
            end else begin
              bitcnt_d = bitcnt_q + 3'd1;
            end
          end else if (scl_fall && full_q) begin
            full_d = 1'b0;
            if (state_q == ADDR) begin
              if (shift_q[7:1] == DEV_ADDR && shift_q[0] == I2C_RW_WRITE) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end else if (cnt_q < 8'(MAX_BYTES)) begin
              state_d = DATA_ACK;
              data_d  = shift_q;
              valid_d = 1'b1;
              cnt_d   = cnt_q + 8'd1;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            state_d  = DATA;
            bitcnt_d = '0;
            idx_d    = '0;
          end
        end
        DATA_ACK: begin
          if (scl_fall) begin
            state_d  = DATA;
            bitcnt_d = '0;
            idx_d    = sat_inc2(idx_q);
          end
        end
        default: ;
      endcase
    end
  end

  // SDA is pulled low exactly while an ACK is owed, so reset releases it straight from the state flop.
  always_comb begin
    sda_oe       = (state_q == ADDR_ACK) || (state_q == DATA_ACK);
    o_data       = data_q;
    o_valid      = valid_q;
    o_idx        = idx_q;
    o_frame_done = done_q;
    o_busy       = busy_q;
  end

  assign io_sdat = sda_oe ? I2C_ACK : 1'bz;

endmodule
